// File: rtl/micro_sequencer_if.sv
// Purpose: groups the micro_sequencer dispatch inputs and status outputs into one bundle.
// Latency: wires only; timing is set by the sequencer that owns the slave side.
// Backpressure: stall is the only hold mechanism; there is no ready path back to the master.
interface micro_sequencer_if #(
  parameter int SW     = 5,
  parameter int NFLAGS = 4,
  parameter int DEPTH  = 4
);
  localparam int CSW = (NFLAGS > 1) ? $clog2(NFLAGS) : 1;
  localparam int DW  = $clog2(DEPTH + 1);

  // dispatch inputs
  logic              stall;
  logic [2:0]        ty;
  logic [SW-1:0]     db_addr;
  logic [SW-1:0]     bc_addr_t;
  logic [SW-1:0]     bc_addr_f;
  logic [CSW-1:0]    cond_sel;
  logic              cond_pol;
  logic [NFLAGS-1:0] flags;
  logic [SW-1:0]     ib_addr;
  logic              ib_valid;
  logic [SW-1:0]     sb_addr;
  logic              mem_ack;
  logic              err_clr;

  // status outputs
  logic [SW-1:0]     state;
  logic              ire_load;
  logic [DW-1:0]     stk_depth;
  logic              err_ovf;
  logic              err_unf;
  logic              err_ill;

  modport master (
    output stall, ty, db_addr, bc_addr_t, bc_addr_f, cond_sel, cond_pol, flags,
           ib_addr, ib_valid, sb_addr, mem_ack, err_clr,
    input  state, ire_load, stk_depth, err_ovf, err_unf, err_ill
  );

  modport slave (
    input  stall, ty, db_addr, bc_addr_t, bc_addr_f, cond_sel, cond_pol, flags,
           ib_addr, ib_valid, sb_addr, mem_ack, err_clr,
    output state, ire_load, stk_depth, err_ovf, err_unf, err_ill
  );
endinterface

// File: rtl/micro_sequencer.sv
// Purpose: next-state engine for the microcoded controller, with return stack and sticky traps.
// Latency: one clock from dispatch sampling to state/stack/error update, no bubbles.
// Backpressure: stall freezes state, stack and errors; WAIT holds until mem_ack.
module micro_sequencer #(
  parameter int SW          = 5,
  parameter int NUM_STATES  = 22,
  parameter int NFLAGS      = 4,
  parameter int DEPTH       = 4,
  parameter int RESET_STATE = 0,
  parameter int TRAP_STATE  = 31
) (
  input  logic             clock,
  input  logic             reset_n,
  micro_sequencer_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);

  localparam logic [SW-1:0] RST_ADDR  = SW'(RESET_STATE);
  localparam logic [SW-1:0] TRAP_ADDR = SW'(TRAP_STATE);
  // one extra bit so NUM_STATES == 2**SW is representable
  localparam logic [SW:0]   STATE_LIM = (SW + 1)'(NUM_STATES);
  localparam logic [DW-1:0] FULL      = DW'(DEPTH);

  typedef enum logic [2:0] {
    TY_IB   = 3'b000,
    TY_SB   = 3'b001,
    TY_BC   = 3'b010,
    TY_DB   = 3'b011,
    TY_CALL = 3'b100,
    TY_RET  = 3'b101,
    TY_WAIT = 3'b110,
    TY_ILL  = 3'b111
  } ty_e;

  logic [SW-1:0] state_q, state_d;
  logic [SW-1:0] stk_q [DEPTH];
  logic [SW-1:0] stk_d [DEPTH];
  logic [DW-1:0] depth_q, depth_d;
  logic          ire_load_q, ire_load_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_unf_q, err_unf_d;
  logic          err_ill_q, err_ill_d;

  logic [SW-1:0] top;
  logic [SW-1:0] nxt;
  logic          addr_sel;
  logic          push;
  logic          pop;
  logic          ib_fire;
  logic          new_ovf;
  logic          new_unf;
  logic          new_ill;
  ty_e           ty;

  assign ty = ty_e'(bus.ty);

  // top-of-stack read: entry depth-1 when the stack is non-empty
  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == DW'(i + 1)) top = stk_q[i];
    end
  end

  // dispatch decode: pick the candidate next address and any stack/error side effects
  always_comb begin
    nxt      = state_q;
    addr_sel = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    ib_fire  = 1'b0;
    new_ovf  = 1'b0;
    new_unf  = 1'b0;
    new_ill  = 1'b0;
    case (ty)
      TY_IB: begin
        if (bus.ib_valid) begin
          nxt      = bus.ib_addr;
          addr_sel = 1'b1;
          ib_fire  = 1'b1;
        end
      end
      TY_SB: begin
        nxt      = bus.sb_addr;
        addr_sel = 1'b1;
      end
      TY_BC: begin
        nxt      = (bus.flags[bus.cond_sel] == bus.cond_pol) ? bus.bc_addr_t : bus.bc_addr_f;
        addr_sel = 1'b1;
      end
      TY_DB: begin
        nxt      = bus.db_addr;
        addr_sel = 1'b1;
      end
      TY_CALL: begin
        if (depth_q < FULL) begin
          push     = 1'b1;
          nxt      = bus.db_addr;
          addr_sel = 1'b1;
        end else begin
          nxt     = TRAP_ADDR;
          new_ovf = 1'b1;
        end
      end
      TY_RET: begin
        if (depth_q != '0) begin
          pop      = 1'b1;
          nxt      = top;
          addr_sel = 1'b1;
        end else begin
          nxt     = TRAP_ADDR;
          new_unf = 1'b1;
        end
      end
      TY_WAIT: begin
        if (bus.mem_ack) begin
          nxt      = bus.db_addr;
          addr_sel = 1'b1;
        end
      end
      default: begin
        nxt     = TRAP_ADDR;
        new_ill = 1'b1;
      end
    endcase
    // range check applies only to addresses taken from the microword or the stack;
    // held states and the trap address itself are never re-flagged
    if (addr_sel && ({1'b0, nxt} >= STATE_LIM)) begin
      nxt     = TRAP_ADDR;
      new_ill = 1'b1;
    end
  end

  // register next values; stall freezes everything and suppresses the ire pulse
  always_comb begin
    state_d    = state_q;
    stk_d      = stk_q;
    depth_d    = depth_q;
    ire_load_d = 1'b0;
    err_ovf_d  = err_ovf_q;
    err_unf_d  = err_unf_q;
    err_ill_d  = err_ill_q;
    if (!bus.stall) begin
      state_d    = nxt;
      ire_load_d = ib_fire;
      if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (depth_q == DW'(i)) stk_d[i] = bus.bc_addr_f;
        end
        depth_d = depth_q + DW'(1);
      end
      if (pop) depth_d = depth_q - DW'(1);
      // a fresh error outranks a coincident clear
      err_ovf_d = (err_ovf_q & ~bus.err_clr) | new_ovf;
      err_unf_d = (err_unf_q & ~bus.err_clr) | new_unf;
      err_ill_d = (err_ill_q & ~bus.err_clr) | new_ill;
    end
  end

  // state, stack and status flops with asynchronous reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RST_ADDR;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
      depth_q    <= '0;
      ire_load_q <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
      err_ill_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stk_q      <= stk_d;
      depth_q    <= depth_d;
      ire_load_q <= ire_load_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
      err_ill_q  <= err_ill_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.ire_load  = ire_load_q;
  assign bus.stk_depth = depth_q;
  assign bus.err_ovf   = err_ovf_q;
  assign bus.err_unf   = err_unf_q;
  assign bus.err_ill   = err_ill_q;
endmodule

// File: tb/tb_micro_sequencer.sv
// Purpose: table-driven scoreboard bench for micro_sequencer.
// Latency: each vector is driven, one posedge elapses, then outputs are compared 1 unit later.
// Backpressure: exercises stall, WAIT/mem_ack and reset priority.
module tb_micro_sequencer;
  logic clock;
  logic reset_n;

  micro_sequencer_if #(.SW(5), .NFLAGS(4), .DEPTH(4)) bus ();

  micro_sequencer #(
    .SW(5), .NUM_STATES(22), .NFLAGS(4), .DEPTH(4), .RESET_STATE(0), .TRAP_STATE(31)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [2:0] IB = 3'd0, SB = 3'd1, BC = 3'd2, DB = 3'd3;
  localparam logic [2:0] CALL = 3'd4, RET = 3'd5, WT = 3'd6, ILL = 3'd7;
  // control bits {ib_valid, mem_ack, stall, err_clr}
  localparam logic [3:0] C0 = 4'b0000, CIBV = 4'b1000, CACK = 4'b0100;
  localparam logic [3:0] CSTL = 4'b0010, CCLR = 4'b0001;
  // error bits {ovf, unf, ill}
  localparam logic [2:0] E0 = 3'b000, EOVF = 3'b100, EUNF = 3'b010, EILL = 3'b001;

  typedef struct packed {
    logic [4:0] state;
    logic       ire;
    logic [2:0] depth;
    logic       ovf;
    logic       unf;
    logic       ill;
  } exp_t;

  typedef struct {
    string      name;
    logic [2:0] ty;
    logic [4:0] db, bt, bf, ib, sb;
    logic [3:0] fl;
    logic [1:0] cs;
    logic       cp;
    logic [3:0] ctl;
    exp_t       exp;
  } vec_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string n, input logic [2:0] ty,
                              input logic [4:0] db, input logic [4:0] bt, input logic [4:0] bf,
                              input logic [3:0] fl, input logic [1:0] cs, input logic cp,
                              input logic [4:0] ib, input logic [4:0] sbv, input logic [3:0] ctl,
                              input logic [4:0] st, input logic ire, input logic [2:0] d,
                              input logic [2:0] errs);
    vec_t v;
    v.name = n; v.ty = ty; v.db = db; v.bt = bt; v.bf = bf; v.fl = fl;
    v.cs = cs; v.cp = cp; v.ib = ib; v.sb = sbv; v.ctl = ctl;
    v.exp = {st, ire, d, errs};
    return v;
  endfunction

  task automatic add(input string n, input logic [2:0] ty,
                     input logic [4:0] db, input logic [4:0] bt, input logic [4:0] bf,
                     input logic [3:0] fl, input logic [1:0] cs, input logic cp,
                     input logic [4:0] ib, input logic [4:0] sbv, input logic [3:0] ctl,
                     input logic [4:0] st, input logic ire, input logic [2:0] d,
                     input logic [2:0] errs);
    vecs.push_back(mk(n, ty, db, bt, bf, fl, cs, cp, ib, sbv, ctl, st, ire, d, errs));
  endtask

  task automatic apply_inputs(input vec_t v);
    bus.ty        = v.ty;
    bus.db_addr   = v.db;
    bus.bc_addr_t = v.bt;
    bus.bc_addr_f = v.bf;
    bus.flags     = v.fl;
    bus.cond_sel  = v.cs;
    bus.cond_pol  = v.cp;
    bus.ib_addr   = v.ib;
    bus.sb_addr   = v.sb;
    bus.ib_valid  = v.ctl[3];
    bus.mem_ack   = v.ctl[2];
    bus.stall     = v.ctl[1];
    bus.err_clr   = v.ctl[0];
  endtask

  task automatic check(input string n);
    exp_t e;
    exp_t a;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty when output was sampled", n);
      return;
    end
    e = sb_q.pop_front();
    a = {bus.state, bus.ire_load, bus.stk_depth, bus.err_ovf, bus.err_unf, bus.err_ill};
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got state=%0d ire=%b depth=%0d ovf=%b unf=%b ill=%b, expected state=%0d ire=%b depth=%0d ovf=%b unf=%b ill=%b",
               n, a.state, a.ire, a.depth, a.ovf, a.unf, a.ill,
               e.state, e.ire, e.depth, e.ovf, e.unf, e.ill);
    end
  endtask

  // drive a vector, let one rising edge commit it, compare shortly after the edge
  task automatic drive(input vec_t v);
    apply_inputs(v);
    sb_q.push_back(v.exp);
    @(posedge clock);
    #1;
    check(v.name);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete within time budget");
    $fatal(1);
  end

  initial begin
    //   name            ty    db  bt  bf  flags   cs cp ib  sb  ctl          st ire d  errs
    add("db6",          DB,    6,  0,  0, 4'b0000, 0, 1, 0,  0, C0,           6, 0, 0, E0);
    add("bc_true",      BC,    0,  6,  7, 4'b0001, 0, 1, 0,  0, C0,           6, 0, 0, E0);
    add("bc_false",     BC,    0,  6,  7, 4'b0000, 0, 1, 0,  0, C0,           7, 0, 0, E0);
    add("bc_pol0_f",    BC,    0, 10, 11, 4'b0100, 2, 0, 0,  0, C0,          11, 0, 0, E0);
    add("bc_pol0_t",    BC,    0, 10, 11, 4'b1011, 2, 0, 0,  0, C0,          10, 0, 0, E0);
    add("sb14",         SB,    0,  0,  0, 4'b0000, 0, 1, 0, 14, C0,          14, 0, 0, E0);
    add("call1",        CALL,  9,  0,  5, 4'b0000, 0, 1, 0,  0, C0,           9, 0, 1, E0);
    add("call2",        CALL,  9,  0,  6, 4'b0000, 0, 1, 0,  0, C0,           9, 0, 2, E0);
    add("call3",        CALL,  9,  0,  8, 4'b0000, 0, 1, 0,  0, C0,           9, 0, 3, E0);
    add("call4",        CALL,  9,  0,  7, 4'b0000, 0, 1, 0,  0, C0,           9, 0, 4, E0);
    add("call_full",    CALL,  9,  0,  3, 4'b0000, 0, 1, 0,  0, C0,          31, 0, 4, EOVF);
    add("ret_top",      RET,   0,  0,  0, 4'b0000, 0, 1, 0,  0, C0,           7, 0, 3, EOVF);
    add("ret2",         RET,   0,  0,  0, 4'b0000, 0, 1, 0,  0, C0,           8, 0, 2, EOVF);
    add("clr_ovf",      SB,    0,  0,  0, 4'b0000, 0, 1, 0,  2, CCLR,         2, 0, 2, E0);
    add("ret3",         RET,   0,  0,  0, 4'b0000, 0, 1, 0,  0, C0,           6, 0, 1, E0);
    add("ret4",         RET,   0,  0,  0, 4'b0000, 0, 1, 0,  0, C0,           5, 0, 0, E0);
    add("ret_empty",    RET,   0,  0,  0, 4'b0000, 0, 1, 0,  0, C0,          31, 0, 0, EUNF);
    add("clr_unf",      DB,    0,  0,  0, 4'b0000, 0, 1, 0,  0, CCLR,         0, 0, 0, E0);
    add("ib_hold1",     IB,    0,  0,  0, 4'b0000, 0, 1, 12, 0, C0,           0, 0, 0, E0);
    add("ib_hold2",     IB,    0,  0,  0, 4'b0000, 0, 1, 12, 0, C0,           0, 0, 0, E0);
    add("ib_hold3",     IB,    0,  0,  0, 4'b0000, 0, 1, 12, 0, C0,           0, 0, 0, E0);
    add("ib_go",        IB,    0,  0,  0, 4'b0000, 0, 1, 12, 0, CIBV,        12, 1, 0, E0);
    add("ire_drop",     DB,   13,  0,  0, 4'b0000, 0, 1, 0,  0, C0,          13, 0, 0, E0);
    add("wait_noack",   WT,    3,  0,  0, 4'b0000, 0, 1, 0,  0, C0,          13, 0, 0, E0);
    add("wait_stall",   WT,    3,  0,  0, 4'b0000, 0, 1, 0,  0, CACK | CSTL, 13, 0, 0, E0);
    add("wait_ack",     WT,    3,  0,  0, 4'b0000, 0, 1, 0,  0, CACK,         3, 0, 0, E0);
    add("ack_ignored",  IB,   20,  0,  0, 4'b0000, 0, 1, 0,  0, CACK,         3, 0, 0, E0);
    add("db25_ill",     DB,   25,  0,  0, 4'b0000, 0, 1, 0,  0, C0,          31, 0, 0, EILL);
    add("clr_vs_new",   ILL,   0,  0,  0, 4'b0000, 0, 1, 0,  0, CCLR,        31, 0, 0, EILL);
    add("clr_ill",      DB,    1,  0,  0, 4'b0000, 0, 1, 0,  0, CCLR,         1, 0, 0, E0);
    add("ty_ill",       ILL,   0,  0,  0, 4'b0000, 0, 1, 0,  0, C0,          31, 0, 0, EILL);
    add("stall_clr",    DB,    4,  0,  0, 4'b0000, 0, 1, 0,  0, CSTL | CCLR, 31, 0, 0, EILL);
    add("clr_ill2",     DB,    4,  0,  0, 4'b0000, 0, 1, 0,  0, CCLR,         4, 0, 0, E0);
    add("ib_stalled",   IB,    0,  0,  0, 4'b0000, 0, 1, 12, 0, CIBV | CSTL,  4, 0, 0, E0);
    add("call_badlink", CALL,  2,  0, 23, 4'b0000, 0, 1, 0,  0, C0,           2, 0, 1, E0);
    add("ret_bad",      RET,   0,  0,  0, 4'b0000, 0, 1, 0,  0, C0,          31, 0, 0, EILL);
    add("call_rst",     CALL,  6,  0,  1, 4'b0000, 0, 1, 0,  0, C0,           6, 0, 1, EILL);
    add("wait_rst",     WT,    3,  0,  0, 4'b0000, 0, 1, 0,  0, C0,           6, 0, 1, EILL);

    // reset state
    apply_inputs(mk("idle", IB, 0, 0, 0, 4'b0000, 0, 1, 0, 0, C0, 0, 0, 0, E0));
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    sb_q.push_back({5'd0, 1'b0, 3'd0, E0});
    check("reset_state");
    #2;
    reset_n = 1'b1;

    foreach (vecs[i]) drive(vecs[i]);

    // asynchronous reset mid-WAIT with a non-empty stack and a sticky error
    #2;
    bus.mem_ack = 1'b1;
    reset_n = 1'b0;
    #1;
    sb_q.push_back({5'd0, 1'b0, 3'd0, E0});
    check("rst_async");
    @(posedge clock);
    #1;
    sb_q.push_back({5'd0, 1'b0, 3'd0, E0});
    check("rst_held");
    #2;
    reset_n = 1'b1;

    // stack really emptied by reset
    drive(mk("ret_after_rst", RET, 0, 0, 0, 4'b0000, 0, 1, 0, 0, C0, 31, 0, 0, EUNF));

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
